// File: rtl/ksa_pkg.sv
// Shared types and defaults for the KSA controller, S-memory and engines.
// State enum, phase codes and a state-to-phase helper.
package ksa_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned KEY_W_DEF  = 24;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StShuf,
    StPrga,
    StDone,
    StErr
  } ksa_state_e;

  typedef enum logic [1:0] {
    PhNone = 2'd0,
    PhInit = 2'd1,
    PhShuf = 2'd2,
    PhPrga = 2'd3
  } ksa_phase_e;

  function automatic ksa_phase_e phase_of(ksa_state_e s);
    case (s)
      StInit:  return PhInit;
      StShuf:  return PhShuf;
      StPrga:  return PhPrga;
      default: return PhNone;
    endcase
  endfunction

endpackage

// File: rtl/ksa_phase_ctrl_if.sv
// Controller-side bundle: run request, engine handshakes, engine memory ports,
// shared S-memory port and status. slave = controller, master = engines/driver.
interface ksa_phase_ctrl_if #(
  parameter int unsigned ADDR_W = ksa_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = ksa_pkg::DATA_W_DEF,
  parameter int unsigned KEY_W  = ksa_pkg::KEY_W_DEF
) ();

  logic              go;
  logic [KEY_W-1:0]  key;
  logic [KEY_W-1:0]  key_q;

  logic              init_start;
  logic              shuf_start;
  logic              prga_start;
  logic              init_done;
  logic              shuf_done;
  logic              prga_done;

  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_wrdata;
  logic              init_wren;
  logic [ADDR_W-1:0] shuf_addr;
  logic [DATA_W-1:0] shuf_wrdata;
  logic              shuf_wren;
  logic [ADDR_W-1:0] prga_addr;
  logic [DATA_W-1:0] prga_wrdata;
  logic              prga_wren;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;

  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        phase;

  modport master (
    output go, key,
    output init_done, shuf_done, prga_done,
    output init_addr, init_wrdata, init_wren,
    output shuf_addr, shuf_wrdata, shuf_wren,
    output prga_addr, prga_wrdata, prga_wren,
    input  key_q, init_start, shuf_start, prga_start,
    input  mem_addr, mem_data, mem_wren,
    input  busy, done, err, phase
  );

  modport slave (
    input  go, key,
    input  init_done, shuf_done, prga_done,
    input  init_addr, init_wrdata, init_wren,
    input  shuf_addr, shuf_wrdata, shuf_wren,
    input  prga_addr, prga_wrdata, prga_wren,
    output key_q, init_start, shuf_start, prga_start,
    output mem_addr, mem_data, mem_wren,
    output busy, done, err, phase
  );

endinterface

// File: rtl/ksa_mem_mux.sv
// Three-to-one S-memory port select keyed by the registered phase code.
// Outside an engine phase the shared port is parked at all-zero.
module ksa_mem_mux import ksa_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  ksa_phase_e        i_phase,
  input  logic [ADDR_W-1:0] i_init_addr,
  input  logic [DATA_W-1:0] i_init_data,
  input  logic              i_init_wren,
  input  logic [ADDR_W-1:0] i_shuf_addr,
  input  logic [DATA_W-1:0] i_shuf_data,
  input  logic              i_shuf_wren,
  input  logic [ADDR_W-1:0] i_prga_addr,
  input  logic [DATA_W-1:0] i_prga_data,
  input  logic              i_prga_wren,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_mem_wren
);

  always_comb begin
    o_mem_addr = '0;
    o_mem_data = '0;
    o_mem_wren = 1'b0;
    unique case (i_phase)
      PhInit: begin
        o_mem_addr = i_init_addr;
        o_mem_data = i_init_data;
        o_mem_wren = i_init_wren;
      end
      PhShuf: begin
        o_mem_addr = i_shuf_addr;
        o_mem_data = i_shuf_data;
        o_mem_wren = i_shuf_wren;
      end
      PhPrga: begin
        o_mem_addr = i_prga_addr;
        o_mem_data = i_prga_data;
        o_mem_wren = i_prga_wren;
      end
      PhNone: begin
      end
    endcase
  end

endmodule

// File: rtl/ksa_phase_ctrl.sv
// Sequencer for the KSA init/shuffle/decrypt engines: start pulses, per-phase
// watchdog, key latch and ownership of the single shared S-memory port.
module ksa_phase_ctrl import ksa_pkg::*; #(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned KEY_W   = KEY_W_DEF,
  parameter int unsigned TIMEOUT = 4096
) (
  input logic             clk,
  input logic             rst_n,
  ksa_phase_ctrl_if.slave bus
);

  localparam int unsigned    WdW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  ksa_state_e        r_state;
  ksa_phase_e        r_phase;
  logic              r_first;
  logic [WdW-1:0]    r_wdog;
  logic [KEY_W-1:0]  r_key;
  logic              r_init_start;
  logic              r_shuf_start;
  logic              r_prga_start;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  ksa_state_e        w_next;
  logic              w_eng_done;
  logic              w_accept;
  logic              w_expire;
  logic              w_go_ok;
  logic              w_enter;
  logic              w_next_busy;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic              w_mem_wren;

  always_comb begin
    case (r_state)
      StInit:  w_eng_done = bus.init_done;
      StShuf:  w_eng_done = bus.shuf_done;
      StPrga:  w_eng_done = bus.prga_done;
      default: w_eng_done = 1'b0;
    endcase
    // r_first masks a done level left over from before this phase started.
    w_accept    = w_eng_done && !r_first;
    w_expire    = (r_wdog == WdLast);
    w_go_ok     = bus.go && (r_state inside {StIdle, StDone, StErr});
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      StIdle, StDone, StErr: if (w_go_ok) w_next = StInit;
      StInit: begin
        if (w_accept)      w_next = StShuf;
        else if (w_expire) w_next = StErr;
      end
      StShuf: begin
        if (w_accept)      w_next = StPrga;
        else if (w_expire) w_next = StErr;
      end
      StPrga: begin
        if (w_accept)      w_next = StDone;
        else if (w_expire) w_next = StErr;
      end
      default: w_next = StIdle;
    endcase
    w_next_busy = w_next inside {StInit, StShuf, StPrga};
    w_enter     = w_next_busy && (w_next != r_state);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_phase      <= PhNone;
      r_first      <= 1'b0;
      r_wdog       <= '0;
      r_key        <= '0;
      r_init_start <= 1'b0;
      r_shuf_start <= 1'b0;
      r_prga_start <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_phase      <= phase_of(w_next);
      r_first      <= w_enter;
      r_init_start <= w_enter && (w_next == StInit);
      r_shuf_start <= w_enter && (w_next == StShuf);
      r_prga_start <= w_enter && (w_next == StPrga);
      r_busy       <= w_next_busy;
      r_done       <= (w_next == StDone);
      r_err        <= (w_next == StErr);
      if (w_enter || !w_next_busy) r_wdog <= '0;
      else                         r_wdog <= r_wdog + WdW'(1);
      if (w_go_ok) r_key <= bus.key;
    end
  end

  ksa_mem_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_mux (
    .i_phase     (r_phase),
    .i_init_addr (bus.init_addr),
    .i_init_data (bus.init_wrdata),
    .i_init_wren (bus.init_wren),
    .i_shuf_addr (bus.shuf_addr),
    .i_shuf_data (bus.shuf_wrdata),
    .i_shuf_wren (bus.shuf_wren),
    .i_prga_addr (bus.prga_addr),
    .i_prga_data (bus.prga_wrdata),
    .i_prga_wren (bus.prga_wren),
    .o_mem_addr  (w_mem_addr),
    .o_mem_data  (w_mem_data),
    .o_mem_wren  (w_mem_wren)
  );

  assign bus.key_q      = r_key;
  assign bus.init_start = r_init_start;
  assign bus.shuf_start = r_shuf_start;
  assign bus.prga_start = r_prga_start;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_data   = w_mem_data;
  assign bus.mem_wren   = w_mem_wren;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.phase      = r_phase;

endmodule

// File: tb/tb_ksa_phase_ctrl.sv
// Randomized bench for ksa_phase_ctrl: two instances (long and short watchdog) run in lockstep;
// a run-level model derives phase windows from engine latencies and checks every cycle.
module tb_ksa_phase_ctrl;
  import ksa_pkg::*;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 8;
  localparam int unsigned KW  = 24;
  localparam int unsigned ToA = 4096;
  localparam int unsigned ToB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ksa_phase_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .KEY_W(KW)) bus_a ();
  ksa_phase_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .KEY_W(KW)) bus_b ();

  ksa_phase_ctrl #(.ADDR_W(AW), .DATA_W(DW), .KEY_W(KW), .TIMEOUT(ToA)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  ksa_phase_ctrl #(.ADDR_W(AW), .DATA_W(DW), .KEY_W(KW), .TIMEOUT(ToB)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  logic          go;
  logic [KW-1:0] key;
  logic [2:0]    eng_done;
  logic [2:0]    eng_wren;
  logic [AW-1:0] eng_addr [3];
  logic [DW-1:0] eng_data [3];
  logic          use_b;
  bit            g_stale0;

  assign bus_a.go = go;             assign bus_b.go = go;
  assign bus_a.key = key;           assign bus_b.key = key;
  assign bus_a.init_done = eng_done[0]; assign bus_b.init_done = eng_done[0];
  assign bus_a.shuf_done = eng_done[1]; assign bus_b.shuf_done = eng_done[1];
  assign bus_a.prga_done = eng_done[2]; assign bus_b.prga_done = eng_done[2];
  assign bus_a.init_addr = eng_addr[0]; assign bus_b.init_addr = eng_addr[0];
  assign bus_a.shuf_addr = eng_addr[1]; assign bus_b.shuf_addr = eng_addr[1];
  assign bus_a.prga_addr = eng_addr[2]; assign bus_b.prga_addr = eng_addr[2];
  assign bus_a.init_wrdata = eng_data[0]; assign bus_b.init_wrdata = eng_data[0];
  assign bus_a.shuf_wrdata = eng_data[1]; assign bus_b.shuf_wrdata = eng_data[1];
  assign bus_a.prga_wrdata = eng_data[2]; assign bus_b.prga_wrdata = eng_data[2];
  assign bus_a.init_wren = eng_wren[0]; assign bus_b.init_wren = eng_wren[0];
  assign bus_a.shuf_wren = eng_wren[1]; assign bus_b.shuf_wren = eng_wren[1];
  assign bus_a.prga_wren = eng_wren[2]; assign bus_b.prga_wren = eng_wren[2];

  // {phase, busy, done, err, init_start, shuf_start, prga_start, mem_wren}
  logic [8:0]    obs_ctl;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_data;
  logic [KW-1:0] obs_key;

  always_comb begin
    if (use_b) begin
      obs_ctl  = {bus_b.phase, bus_b.busy, bus_b.done, bus_b.err, bus_b.init_start,
                  bus_b.shuf_start, bus_b.prga_start, bus_b.mem_wren};
      obs_addr = bus_b.mem_addr;
      obs_data = bus_b.mem_data;
      obs_key  = bus_b.key_q;
    end else begin
      obs_ctl  = {bus_a.phase, bus_a.busy, bus_a.done, bus_a.err, bus_a.init_start,
                  bus_a.shuf_start, bus_a.prga_start, bus_a.mem_wren};
      obs_addr = bus_a.mem_addr;
      obs_data = bus_a.mem_data;
      obs_key  = bus_a.key_q;
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ap = index of the engine that owns the phase (-1 for none), off = cycle within the phase.
  task automatic drive_engines(input int ap, input int off, input int n_ap, input bit wr_others);
    for (int e = 0; e < 3; e++) begin
      eng_addr[e] = AW'($urandom);
      eng_data[e] = DW'($urandom);
      eng_wren[e] = (wr_others && e != ap) ? 1'b1 : 1'($urandom);
      if (g_stale0 && e == 0)  eng_done[e] = 1'b1;
      else if (e == ap)        eng_done[e] = (off == n_ap) || (off == 0 && $urandom_range(1) == 1);
      else                     eng_done[e] = 1'($urandom);
    end
  endtask

  task automatic check_idle(input int cycles, input bit exp_done, input bit exp_err,
                            input logic [KW-1:0] exp_key, input string tag);
    for (int c = 0; c < cycles; c++) begin
      drive_engines(-1, 0, 0, 1'b0);
      go  = 1'b0;
      key = KW'($urandom);
      #2;
      check_eq($sformatf("%s_ctl c=%0d", tag, c), 64'(obs_ctl),
               64'({2'b00, 1'b0, exp_done, exp_err, 4'b0000}));
      check_eq($sformatf("%s_addr c=%0d", tag, c), 64'(obs_addr), 64'(0));
      check_eq($sformatf("%s_key c=%0d", tag, c), 64'(obs_key), 64'(exp_key));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    go = 1'b0;
    rst_n = 1'b0;
    drive_engines(-1, 0, 0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    check_eq("reset_ctl", 64'(obs_ctl), 64'(0));
    check_eq("reset_key", 64'(obs_key), 64'(0));
    check_eq("reset_mem", 64'({obs_addr, obs_data}), 64'(0));
    rst_n = 1'b1;
  endtask

  // One full request: engine p raises done n[p] cycles after its start cycle.
  task automatic run_seq(input logic [KW-1:0] k, input int n0, input int n1, input int n2,
                         input int abort_at, input bit wr_others);
    int to;
    int n[3];
    int st[3];
    int len[3];
    int nph;
    int total;
    bit tmo;
    logic [8:0] exp_ctl;
    to = use_b ? int'(ToB) : int'(ToA);
    n[0] = n0; n[1] = n1; n[2] = n2;
    nph = 0; total = 0; tmo = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (!tmo) begin
        st[p] = 1 + total;
        if (n[p] <= to - 1) len[p] = n[p] + 1;
        else begin
          len[p] = to;
          tmo = 1'b1;
        end
        total += len[p];
        nph = p + 1;
      end
    end

    go = 1'b1;
    key = k;
    drive_engines(-1, 0, 0, wr_others);
    @(posedge clk); #1;

    for (int t = 1; t <= total + 2; t++) begin
      int ap;
      int off;
      ap = -1; off = 0;
      for (int p = 0; p < nph; p++)
        if (t >= st[p] && t < st[p] + len[p]) begin
          ap = p;
          off = t - st[p];
        end
      drive_engines(ap, off, (ap >= 0) ? n[ap] : 0, wr_others);
      go  = (ap >= 0) ? ($urandom_range(3) == 0) : 1'b0;
      key = KW'($urandom);
      #2;
      if (ap >= 0) begin
        exp_ctl = {2'(ap + 1), 1'b1, 1'b0, 1'b0, (off == 0 && ap == 0),
                   (off == 0 && ap == 1), (off == 0 && ap == 2), eng_wren[ap]};
        check_eq($sformatf("run_addr t=%0d", t), 64'(obs_addr), 64'(eng_addr[ap]));
        check_eq($sformatf("run_data t=%0d", t), 64'(obs_data), 64'(eng_data[ap]));
      end else begin
        exp_ctl = {2'b00, 1'b0, !tmo, tmo, 4'b0000};
        check_eq($sformatf("end_mem t=%0d", t), 64'({obs_addr, obs_data}), 64'(0));
      end
      check_eq($sformatf("run_ctl t=%0d", t), 64'(obs_ctl), 64'(exp_ctl));
      check_eq($sformatf("run_key t=%0d", t), 64'(obs_key), 64'(k));
      if (t == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_eq("abort_ctl", 64'(obs_ctl), 64'(0));
        check_eq("abort_mem", 64'({obs_addr, obs_data}), 64'(0));
        check_eq("abort_key", 64'(obs_key), 64'(0));
        @(posedge clk); #1;
        go = 1'b0;
        rst_n = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    go = 1'b0;
  endtask

  initial begin
    go = 1'b0; key = '0; eng_done = '0; eng_wren = '0;
    for (int e = 0; e < 3; e++) begin
      eng_addr[e] = '0;
      eng_data[e] = '0;
    end
    use_b = 1'b0;
    g_stale0 = 1'b0;

    do_reset();
    check_idle(4, 1'b0, 1'b0, '0, "post_reset");

    run_seq(24'h000249, 256, 768, 40, 0, 1'b0);
    check_idle(3, 1'b1, 1'b0, 24'h000249, "done_hold");

    run_seq(24'h5a5a5a, 5, 30, 6, 0, 1'b1);

    g_stale0 = 1'b1;
    do_reset();
    run_seq(24'h123456, 1, 12, 9, 0, 1'b0);
    g_stale0 = 1'b0;

    for (int i = 0; i < 6; i++)
      run_seq(KW'($urandom), $urandom_range(1, 60), $urandom_range(1, 60),
              $urandom_range(1, 60), 0, 1'($urandom));

    // PRGA starts at cycle 43 with these latencies; pull reset in its middle.
    run_seq(24'hc0ffee, 20, 20, 30, 53, 1'b0);
    check_idle(3, 1'b0, 1'b0, '0, "after_abort");

    use_b = 1'b1;
    do_reset();
    run_seq(24'h0badf0, 5, 2000, 5, 0, 1'b0);
    check_idle(2, 1'b0, 1'b1, 24'h0badf0, "err_hold");
    run_seq(24'h777777, 15, 15, 15, 0, 1'b1);
    run_seq(24'h010203, 16, 3, 3, 0, 1'b0);
    for (int i = 0; i < 6; i++)
      run_seq(KW'($urandom), $urandom_range(1, 18), $urandom_range(1, 18),
              $urandom_range(1, 18), 0, 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
